// File: rtl/iir_coeff_loader.sv
// Coefficient writer for one biquad notch stage: gathers config writes in shadow
// registers and applies them atomically to the IIR's parallel load interface on commit.
module iir_coeff_loader #(
  parameter int COEFF_WIDTH     = 20,
  parameter int NUM_COEFF_DEPTH = 3,
  parameter int DEN_COEFF_DEPTH = 2
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             cfg_valid,
  input  logic [2:0]                                       cfg_addr,
  input  logic signed [COEFF_WIDTH-1:0]                    cfg_data,
  input  logic                                             cfg_commit,
  output logic                                             cfg_ready,
  output logic                                             cfg_err,
  input  logic                                             hold,
  output logic [NUM_COEFF_DEPTH-1:0][COEFF_WIDTH-1:0]      num_coeff_in,
  output logic [DEN_COEFF_DEPTH-1:0][COEFF_WIDTH-1:0]      den_coeff_in,
  output logic                                             num_coeff_wr_en,
  output logic                                             den_coeff_wr_en,
  output logic                                             commit_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WR_NUM = 2'd1,
    S_WR_DEN = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [COEFF_WIDTH-1:0] r_sh_b     [NUM_COEFF_DEPTH];
  logic signed [COEFF_WIDTH-1:0] r_sh_a     [DEN_COEFF_DEPTH];
  logic signed [COEFF_WIDTH-1:0] w_sh_b_nxt [NUM_COEFF_DEPTH];
  logic signed [COEFF_WIDTH-1:0] w_sh_a_nxt [DEN_COEFF_DEPTH];

  logic r_num_dirty, r_den_dirty;
  logic w_num_dirty_nxt, w_den_dirty_nxt;
  logic r_pend_num, r_pend_den;
  logic w_wr_acc, w_commit_acc, w_addr_bad;

  assign w_wr_acc     = cfg_valid  & cfg_ready;
  assign w_commit_acc = cfg_commit & cfg_ready;

  // Shadow update with the incoming write folded in, so a write accepted in the
  // same cycle as a commit lands in the staged arrays and pend flags.
  always_comb begin
    w_sh_b_nxt      = r_sh_b;
    w_sh_a_nxt      = r_sh_a;
    w_num_dirty_nxt = r_num_dirty;
    w_den_dirty_nxt = r_den_dirty;
    w_addr_bad      = 1'b1;
    for (int i = 0; i < NUM_COEFF_DEPTH; i++) begin
      if (cfg_addr == 3'(i)) begin
        w_addr_bad = 1'b0;
        if (w_wr_acc) begin
          w_sh_b_nxt[i]   = cfg_data;
          w_num_dirty_nxt = 1'b1;
        end
      end
    end
    for (int i = 0; i < DEN_COEFF_DEPTH; i++) begin
      if (cfg_addr == 3'(NUM_COEFF_DEPTH + i)) begin
        w_addr_bad = 1'b0;
        if (w_wr_acc) begin
          w_sh_a_nxt[i]   = cfg_data;
          w_den_dirty_nxt = 1'b1;
        end
      end
    end
  end

  // Strobes are sequenced one state apart: the IIR drops a denominator load that
  // coincides with a numerator load.
  always_comb begin
    w_state_nxt     = r_state;
    num_coeff_wr_en = 1'b0;
    den_coeff_wr_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_commit_acc) w_state_nxt = S_WR_NUM;
      end
      S_WR_NUM: begin
        num_coeff_wr_en = r_pend_num & ~hold;
        if (!hold) w_state_nxt = S_WR_DEN;
      end
      S_WR_DEN: begin
        den_coeff_wr_en = r_pend_den & ~hold;
        if (!hold) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Stage p0: state, shadows, staged arrays and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      cfg_ready   <= 1'b1;
      cfg_err     <= 1'b0;
      commit_done <= 1'b0;
      r_num_dirty <= 1'b0;
      r_den_dirty <= 1'b0;
      r_pend_num  <= 1'b0;
      r_pend_den  <= 1'b0;
      for (int i = 0; i < NUM_COEFF_DEPTH; i++) begin
        r_sh_b[i]       <= '0;
        num_coeff_in[i] <= '0;
      end
      for (int i = 0; i < DEN_COEFF_DEPTH; i++) begin
        r_sh_a[i]       <= '0;
        den_coeff_in[i] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      cfg_ready   <= (w_state_nxt == S_IDLE);
      cfg_err     <= w_wr_acc & w_addr_bad;
      commit_done <= (w_state_nxt == S_DONE);
      r_sh_b      <= w_sh_b_nxt;
      r_sh_a      <= w_sh_a_nxt;
      if (w_commit_acc) begin
        r_num_dirty <= 1'b0;
        r_den_dirty <= 1'b0;
        r_pend_num  <= w_num_dirty_nxt;
        r_pend_den  <= w_den_dirty_nxt;
        for (int i = 0; i < NUM_COEFF_DEPTH; i++) num_coeff_in[i] <= w_sh_b_nxt[i];
        for (int i = 0; i < DEN_COEFF_DEPTH; i++) den_coeff_in[i] <= w_sh_a_nxt[i];
      end else begin
        r_num_dirty <= w_num_dirty_nxt;
        r_den_dirty <= w_den_dirty_nxt;
      end
    end
  end

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Scoreboard bench for iir_coeff_loader: a plain array model predicts staged
// arrays and event cycles; a negedge monitor pops expectations as the DUT emits them.
module tb_iir_coeff_loader;
  localparam int W  = 20;
  localparam int NB = 3;
  localparam int NA = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0, cfg_commit = 1'b0, hold = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [W-1:0] cfg_data = '0;
  logic cfg_ready, cfg_err, num_coeff_wr_en, den_coeff_wr_en, commit_done;
  logic [NB-1:0][W-1:0] num_coeff_in;
  logic [NA-1:0][W-1:0] den_coeff_in;

  iir_coeff_loader #(.COEFF_WIDTH(W), .NUM_COEFF_DEPTH(NB), .DEN_COEFF_DEPTH(NA)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_ready(cfg_ready), .cfg_err(cfg_err), .hold(hold),
    .num_coeff_in(num_coeff_in), .den_coeff_in(den_coeff_in),
    .num_coeff_wr_en(num_coeff_wr_en), .den_coeff_wr_en(den_coeff_wr_en),
    .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic [W-1:0] m_b [NB];
  logic [W-1:0] m_a [NA];
  logic m_nd, m_dd;
  logic [NB-1:0][W-1:0] exp_num;
  logic [NA-1:0][W-1:0] exp_den;
  int exp_ready_cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int cyc;
    logic [NB-1:0][W-1:0] num;
    logic [NA-1:0][W-1:0] den;
  } ev_t;
  ev_t q_num[$];
  ev_t q_den[$];
  int  q_done[$];
  int  q_err[$];
  ev_t mon_ev;
  int  mon_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("cfg_ready", 64'(cfg_ready), 64'(cyc >= exp_ready_cyc));
      chk("num_coeff_in", 64'(num_coeff_in), 64'(exp_num));
      chk("den_coeff_in", 64'(den_coeff_in), 64'(exp_den));
      chk("strobe_overlap", 64'(num_coeff_wr_en & den_coeff_wr_en), 64'(0));
      if (num_coeff_wr_en) begin
        if (q_num.size() == 0) chk("num_wr_en_unexpected", 64'(num_coeff_wr_en), 64'(0));
        else begin
          mon_ev = q_num.pop_front();
          chk("num_wr_en_cycle", 64'(cyc), 64'(mon_ev.cyc));
          chk("num_at_strobe", 64'(num_coeff_in), 64'(mon_ev.num));
        end
      end
      if (den_coeff_wr_en) begin
        if (q_den.size() == 0) chk("den_wr_en_unexpected", 64'(den_coeff_wr_en), 64'(0));
        else begin
          mon_ev = q_den.pop_front();
          chk("den_wr_en_cycle", 64'(cyc), 64'(mon_ev.cyc));
          chk("den_at_strobe", 64'(den_coeff_in), 64'(mon_ev.den));
        end
      end
      if (commit_done) begin
        if (q_done.size() == 0) chk("commit_done_unexpected", 64'(commit_done), 64'(0));
        else begin
          mon_t = q_done.pop_front();
          chk("commit_done_cycle", 64'(cyc), 64'(mon_t));
        end
      end
      if (cfg_err) begin
        if (q_err.size() == 0) chk("cfg_err_unexpected", 64'(cfg_err), 64'(0));
        else begin
          mon_t = q_err.pop_front();
          chk("cfg_err_cycle", 64'(cyc), 64'(mon_t));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_b[i] = '0;
    for (int i = 0; i < NA; i++) m_a[i] = '0;
    m_nd = 1'b0;
    m_dd = 1'b0;
    exp_num = '0;
    exp_den = '0;
  endtask

  task automatic model_write(input int a, input logic [W-1:0] d, input int t);
    if (a < NB) begin
      m_b[a] = d;
      m_nd = 1'b1;
    end else if (a < NB + NA) begin
      m_a[a-NB] = d;
      m_dd = 1'b1;
    end else begin
      q_err.push_back(t);
    end
  endtask

  task automatic do_write(input int a, input logic [W-1:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = 3'(a);
    cfg_data  = d;
    tick();
    cfg_valid = 1'b0;
    model_write(a, d, cyc);
  endtask

  // Commit accepted at edge t; strobes/done then land at cycles derived from hold lengths.
  task automatic do_commit(input bit wr, input int a, input logic [W-1:0] d,
                           input int hn, input int hd, input bit junk, input bit rst_mid);
    ev_t ev;
    int t;
    bit pn, pd;
    cfg_commit = 1'b1;
    if (wr) begin
      cfg_valid = 1'b1;
      cfg_addr  = 3'(a);
      cfg_data  = d;
    end
    tick();
    t = cyc;
    cfg_commit = 1'b0;
    cfg_valid  = 1'b0;
    if (wr) model_write(a, d, t);
    for (int i = 0; i < NB; i++) exp_num[i] = m_b[i];
    for (int i = 0; i < NA; i++) exp_den[i] = m_a[i];
    ev.num = exp_num;
    ev.den = exp_den;
    pn = m_nd;
    pd = m_dd;
    m_nd = 1'b0;
    m_dd = 1'b0;
    if (junk) begin
      cfg_valid  = 1'b1;
      cfg_commit = 1'($urandom);
      cfg_addr   = 3'($urandom);
      cfg_data   = W'($urandom);
    end
    if (rst_mid) begin
      exp_ready_cyc = t + 3;
      if (pn) begin ev.cyc = t; q_num.push_back(ev); end
      tick();
      hold = 1'b1;
      rst  = 1'b1;
      tick();
      rst = 1'b0;
      hold = 1'b0;
      cfg_valid = 1'b0;
      cfg_commit = 1'b0;
      model_reset();
      exp_ready_cyc = cyc;
    end else begin
      if (pn) begin ev.cyc = t + hn; q_num.push_back(ev); end
      if (pd) begin ev.cyc = t + hn + 1 + hd; q_den.push_back(ev); end
      q_done.push_back(t + hn + hd + 2);
      exp_ready_cyc = t + hn + hd + 3;
      hold = (hn > 0);
      repeat (hn) tick();
      hold = 1'b0;
      tick();
      hold = (hd > 0);
      repeat (hd) tick();
      hold = 1'b0;
      tick();
      tick();
      cfg_valid  = 1'b0;
      cfg_commit = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
    exp_ready_cyc = cyc;
    tick();
    rst = 1'b0;
    tick();

    // Full commit with all five coefficients
    do_write(0, 20'h37061);
    do_write(1, 20'h5907C);
    do_write(2, 20'h37061);
    do_write(3, 20'h5907C);
    do_write(4, 20'h2E0C3);
    do_commit(1'b0, 0, '0, 0, 0, 1'b0, 1'b0);
    tick();

    // Numerator-only commit
    do_write(1, 20'hC8F9F);
    do_commit(1'b0, 0, '0, 0, 0, 1'b0, 1'b0);
    tick();

    // Hold deferral for two cycles in WR_NUM
    do_write(0, 20'h0ABCD);
    do_write(3, 20'hFEDCB);
    do_commit(1'b0, 0, '0, 2, 0, 1'b0, 1'b0);

    // Invalid address, then write+commit in one cycle
    do_write(6, 20'h7FFFF);
    do_commit(1'b1, 4, 20'h12345, 0, 0, 1'b0, 1'b0);
    chk("den1_after_same_cycle_commit", 64'(den_coeff_in[1]), 64'(20'h12345));

    // Empty commit, busy traffic ignored, then reset mid-commit
    do_commit(1'b0, 0, '0, 0, 0, 1'b1, 1'b0);
    do_write(2, 20'h80000);
    do_write(4, 20'h00001);
    do_commit(1'b0, 0, '0, 0, 1, 1'b1, 1'b0);
    do_write(0, 20'h11111);
    do_write(3, 20'h22222);
    do_commit(1'b0, 0, '0, 0, 0, 1'b1, 1'b1);
    tick();

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int k = 0; k < nw; k++) do_write($urandom_range(0, 7), W'($urandom));
      do_commit(1'($urandom), $urandom_range(0, 7), W'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom), ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (4) tick();
    chk("num_queue_drained", 64'(q_num.size()), 64'(0));
    chk("den_queue_drained", 64'(q_den.size()), 64'(0));
    chk("done_queue_drained", 64'(q_done.size()), 64'(0));
    chk("err_queue_drained", 64'(q_err.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
